cla_add_sched: RTL and testbench



---
 rtl/cla_sched_pkg.sv | 12 +
 rtl/cla_add_sched_arb.sv | 38 +++
 rtl/cla_add_sched.sv | 143 ++++++++++++++
 tb/tb_cla_add_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_sched_pkg.sv
// Shared types and constants for the nibble-serial CLA adder scheduler.
package cla_sched_pkg;
  localparam int NIBBLE_W = 4;
  localparam int ID_W     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/cla_add_sched_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// pointer, and the pointer moves past whichever requester was accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);
  logic ptr_q;
  logic ptr_d;

  // Grant decode and pointer next-state
  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    if (accept_i) begin
      ptr_d = ~grant_o[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/cla_add_sched.sv
// Shares one registered 4-bit adder between two requesters, sequencing a wide
// add one nibble per ISSUE/WAIT pair and returning the sum over a handshake.
module cla_add_sched
  import cla_sched_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] req0_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] req0_b,
  input  logic                    req0_cin,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] req1_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] req1_b,
  input  logic                    req1_cin,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [NIBBLE_W*NIBBLES-1:0] resp_sum,
  output logic                    resp_cout,
  output logic [NIBBLE_W-1:0]     add_x,
  output logic [NIBBLE_W-1:0]     add_y,
  output logic                    add_cin,
  input  logic [NIBBLE_W-1:0]     add_z,
  input  logic                    add_cout
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [1:0]      grant_s;
  logic            idle_s;
  logic            accept_s;

  assign idle_s     = (state_q == ST_IDLE);
  assign accept_s   = idle_s & (|grant_s);
  assign req0_ready = idle_s & grant_s[0];
  assign req1_ready = idle_s & grant_s[1];
  assign resp_valid = (state_q == ST_DONE);
  assign resp_sum   = sum_q;
  assign resp_cout  = carry_q;
  assign resp_id    = id_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (accept_s),
    .grant_o  (grant_s)
  );

  // Sequencer next-state and adder drive
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    id_d    = id_q;
    add_x   = {NIBBLE_W{1'b0}};
    add_y   = {NIBBLE_W{1'b0}};
    add_cin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (grant_s[1]) begin
            a_d     = req1_a;
            b_d     = req1_b;
            carry_d = req1_cin;
            id_d    = ID_W'(1);
          end else begin
            a_d     = req0_a;
            b_d     = req0_b;
            carry_d = req0_cin;
            id_d    = ID_W'(0);
          end
          k_d     = {KW{1'b0}};
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        add_x   = a_q[NIBBLE_W*k_q +: NIBBLE_W];
        add_y   = b_q[NIBBLE_W*k_q +: NIBBLE_W];
        add_cin = carry_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The adder registers its result, so it is valid one cycle after ISSUE.
        sum_d[NIBBLE_W*k_q +: NIBBLE_W] = add_z;
        carry_d = add_cout;
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, operand, sum and carry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      carry_q <= 1'b0;
      k_q     <= {KW{1'b0}};
      id_q    <= {ID_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      id_q    <= id_d;
    end
  end
endmodule

// File: tb/tb_cla_add_sched.sv
// Directed bench for cla_add_sched with a behavioural registered 4-bit adder.
module tb_cla_add_sched;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [0:0]   resp_id;
  logic [W-1:0] resp_sum;
  logic         resp_cout;
  logic [3:0]   add_x, add_y, add_z;
  logic         add_cin, add_cout;

  int total = 0;
  int bad = 0;

  cla_add_sched #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_z(add_z), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Registered 4-bit adder: result appears the cycle after the operands.
  always @(posedge clk) begin
    {add_cout, add_z} <= {1'b0, add_x} + {1'b0, add_y} + {4'b0000, add_cin};
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "time limit");
  end

  // Runs one transaction from IDLE (#1 after a rising edge) and returns observations.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                         input int bp,
                         output logic hs_ok, output logic gid, output int lat,
                         output logic [3:0] cin_mask, output logic [3:0] x0, output logic [3:0] y0,
                         output logic [W-1:0] sum, output logic cout, output logic rid,
                         output logic hold_ok);
    int n;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    resp_ready = (bp == 0);
    hs_ok = 1'b0; gid = 1'b0; lat = 0; cin_mask = 4'h0; x0 = 4'h0; y0 = 4'h0;
    sum = '0; cout = 1'b0; rid = 1'b0; hold_ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    hs_ok = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    gid = req1_valid && req1_ready;
    if (hs_ok) begin
      while (!resp_valid && lat < 40) begin
        @(negedge clk);
        lat++;
        if ((lat % 2) == 1 && lat <= 7) begin
          cin_mask[(lat - 1) / 2] = add_cin;
          if (lat == 1) begin
            x0 = add_x;
            y0 = add_y;
          end
        end
      end
      if (resp_valid) begin
        sum = resp_sum; cout = resp_cout; rid = resp_id;
        for (int i = 1; i < bp; i++) begin
          @(negedge clk);
          if (!resp_valid || resp_sum !== sum || resp_cout !== cout || resp_id !== rid ||
              req0_ready || req1_ready || add_x !== 4'h0 || add_y !== 4'h0 || add_cin !== 1'b0)
            hold_ok = 1'b0;
        end
        if (bp > 0) begin
          @(posedge clk); #1;
          resp_ready = 1'b1;
          @(negedge clk);
          if (!resp_valid || resp_sum !== sum) hold_ok = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_sum !== 16'h0000) begin bad++; $display("FAIL reset_resp_sum got=%h want=0000", resp_sum); end
    total++; if ({resp_cout, resp_id} !== 2'b00) begin bad++; $display("FAIL reset_cout_id got=%b want=00", {resp_cout, resp_id}); end
    total++; if ({add_x, add_y, add_cin} !== 9'h000) begin bad++; $display("FAIL reset_adder got=%h want=000", {add_x, add_y, add_cin}); end
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL reset_readys got=%b want=00", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic hs, gid, rid, cout, hold; int lat; logic [3:0] cm, x0, y0; logic [W-1:0] sum;
    run_txn(1'b1, 1'b0, 16'h1234, 16'h0FEE, 1'b0, 16'h0000, 16'h0000, 1'b0, 0,
            hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
    total++; if (!(hs && gid == 1'b0)) begin bad++; $display("FAIL single_handshake got=%b/%b want=1/0", hs, gid); end
    total++; if (lat !== 9) begin bad++; $display("FAIL single_latency got=%0d want=9", lat); end
    total++; if ({x0, y0} !== 8'h4E) begin bad++; $display("FAIL single_issue0 got=%h want=4e", {x0, y0}); end
    total++; if (sum !== 16'h2222) begin bad++; $display("FAIL single_sum got=%h want=2222", sum); end
    total++; if ({cout, rid} !== 2'b00) begin bad++; $display("FAIL single_cout_id got=%b want=00", {cout, rid}); end
  endtask

  task automatic test_carry_chain;
    logic hs, gid, rid, cout, hold; int lat; logic [3:0] cm, x0, y0; logic [W-1:0] sum;
    run_txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 0,
            hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
    total++; if (cm !== 4'hF) begin bad++; $display("FAIL chain_add_cin got=%b want=1111", cm); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL chain_sum got=%h want=0000", sum); end
    total++; if (cout !== 1'b1) begin bad++; $display("FAIL chain_cout got=%b want=1", cout); end
  endtask

  task automatic test_simultaneous;
    logic hs, gid, rid, cout, hold; int lat; logic [3:0] cm, x0, y0; logic [W-1:0] sum;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 16'h0003, 16'h000A, 1'b0, 16'h8000, 16'h8000, 1'b0, 0,
            hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
    total++; if ({rid, sum, cout} !== {1'b0, 16'h000D, 1'b0}) begin bad++;
      $display("FAIL simul_first got=id%b sum%h c%b want=id0 sum000d c0", rid, sum, cout); end
    run_txn(1'b0, 1'b1, 16'h0003, 16'h000A, 1'b0, 16'h8000, 16'h8000, 1'b0, 0,
            hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
    total++; if ({rid, sum, cout} !== {1'b1, 16'h0000, 1'b1}) begin bad++;
      $display("FAIL simul_second got=id%b sum%h c%b want=id1 sum0000 c1", rid, sum, cout); end
  endtask

  task automatic test_fairness;
    logic hs, gid, rid, cout, hold; int lat; logic [3:0] cm, x0, y0; logic [W-1:0] sum;
    logic [3:0] ids; logic sums_ok;
    ids = 4'h0; sums_ok = 1'b1;
    for (int t = 0; t < 4; t++) begin
      run_txn(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 0,
              hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
      ids[t] = rid;
      if (sum !== (rid ? 16'h8000 : 16'h3333)) sums_ok = 1'b0;
    end
    total++; if (ids !== 4'b1010) begin bad++; $display("FAIL fair_ids got=%b want=1010 (bit0 first)", ids); end
    total++; if (sums_ok !== 1'b1) begin bad++; $display("FAIL fair_sums got=%b want=1", sums_ok); end
  endtask

  task automatic test_backpressure;
    logic hs, gid, rid, cout, hold; int lat; logic [3:0] cm, x0, y0; logic [W-1:0] sum;
    run_txn(1'b1, 1'b0, 16'h00F0, 16'h0F10, 1'b0, 16'h0000, 16'h0000, 1'b0, 5,
            hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b want=1", hold); end
    total++; if (sum !== 16'h1000) begin bad++; $display("FAIL bp_sum got=%h want=1000", sum); end
    req0_valid = 1'b1;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b want=1", req0_ready); end
    req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    logic hs, gid, rid, cout, hold; int lat; logic [3:0] cm, x0, y0; logic [W-1:0] sum;
    logic seen;
    req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b0;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL midop_accept got=%b want=1", req0_ready); end
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 req0_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if ({resp_valid, resp_sum, resp_cout, resp_id, add_x, add_y, add_cin, req0_ready, req1_ready} !== 31'h0) begin
      bad++; $display("FAIL midop_zero got=%b%h%b%b%h%h%b%b%b want=all zero", resp_valid, resp_sum, resp_cout,
                      resp_id, add_x, add_y, add_cin, req0_ready, req1_ready); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midop_no_resp got=%b want=0", seen); end
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h1000, 16'h1000, 1'b0, 0,
            hs, gid, lat, cm, x0, y0, sum, cout, rid, hold);
    total++; if ({rid, sum, cout} !== {1'b0, 16'h0100, 1'b0}) begin bad++;
      $display("FAIL midop_after got=id%b sum%h c%b want=id0 sum0100 c0", rid, sum, cout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry_chain();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
